// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying ctrl+data under valid/ready; one-cycle latency, no bypass.
// Backpressure: SKID=1 holds two entries with a registered in_ready; SKID=0 holds one with in_ready = ~out_valid | out_ready.
module pipe_stage_reg #(
  parameter int CTRL_W    = 8,
  parameter int DATA_W    = 96,
  parameter int SKID      = 1,
  parameter int ZERO_DATA = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_accept;
  logic              w_emit;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_accept && !w_emit)      w_state_nxt = (SKID != 0) ? S_TWO : S_ONE;
          else if (!w_accept && w_emit) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_emit) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // SKID=1 derives in_ready from the state register only, breaking the ready path.
  always_comb begin
    out_valid = (r_state != S_EMPTY);
    if (SKID != 0) in_ready = (r_state != S_TWO);
    else           in_ready = (r_state == S_EMPTY) | out_ready;
    out_ctrl  = out_valid ? r_main_ctrl : '0;
    out_data  = r_main_data;
    stall_cnt = r_stall_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      if (ZERO_DATA != 0) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end
        end
        S_ONE: begin
          if (w_accept && w_emit) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_accept) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
          end
        end
        S_TWO: begin
          if (w_emit) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: two SKID=1 stages (data retained / data zeroed on flush) sharing stimulus, plus one SKID=0 stage.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_ctrl;
  logic [31:0] s_out_data;
  logic [3:0]  s_stall;
  logic        z_in_ready, z_out_valid;
  logic [7:0]  z_out_ctrl;
  logic [31:0] z_out_data;
  logic [3:0]  z_stall;

  logic        p_flush, p_in_valid, p_out_ready, p_in_ready, p_out_valid;
  logic [7:0]  p_in_ctrl, p_out_ctrl;
  logic [31:0] p_in_data, p_out_data;
  logic [15:0] p_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(1), .ZERO_DATA(0), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .stall_cnt(s_stall));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(1), .ZERO_DATA(1), .CNT_W(4)) dut_z (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_ctrl(z_out_ctrl), .out_data(z_out_data), .stall_cnt(z_stall));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(0), .ZERO_DATA(0), .CNT_W(16)) dut_p (
    .clk(clk), .reset(reset), .flush(p_flush), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_ctrl(p_in_ctrl), .in_data(p_in_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_ctrl(p_out_ctrl), .out_data(p_out_data), .stall_cnt(p_stall));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    p_flush = 1'b0; p_in_valid = 1'b0; p_in_ctrl = '0; p_in_data = '0; p_out_ready = 1'b0;
    #1;
    chk("rst_in_ready", s_in_ready, 1);
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_out_ctrl", s_out_ctrl, 0);
    chk("rst_out_data", s_out_data, 0);
    chk("rst_stall", s_stall, 0);
    chk("rst_p_in_ready", p_in_ready, 1);
    tick();
    reset = 1'b1;

    // Streaming: one-cycle latency, in order, in_ready stays high.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = 8'(i); in_data = 32'h100 + 32'(i);
      #1;
      chk("stream_in_ready", s_in_ready, 1);
      tick();
      chk("stream_out_valid", s_out_valid, 1);
      chk("stream_out_ctrl", s_out_ctrl, 64'(i));
      chk("stream_out_data", s_out_data, 64'h100 + 64'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", s_out_valid, 0);
    chk("stream_stall", s_stall, 0);

    // Backpressure: two accepts fill the skid, then drain in order.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11; in_data = 32'hA11;
    tick();
    chk("bp_a_ctrl", s_out_ctrl, 8'h11);
    chk("bp_a_in_ready", s_in_ready, 1);
    in_ctrl = 8'h22; in_data = 32'hB22;
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_full_in_ready", s_in_ready, 0);
    chk("bp_full_ctrl", s_out_ctrl, 8'h11);
    chk("bp_full_data", s_out_data, 32'hA11);
    chk("bp_stall", s_stall, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_rel_head", s_out_ctrl, 8'h11);
    tick();
    chk("bp_second_ctrl", s_out_ctrl, 8'h22);
    chk("bp_second_data", s_out_data, 32'hB22);
    chk("bp_second_in_ready", s_in_ready, 1);
    tick();
    chk("bp_drained", s_out_valid, 0);
    chk("bp_stall_after", s_stall, 1);

    // Flush in state TWO with an incoming entry.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h33; in_data = 32'hC33;
    tick();
    in_ctrl = 8'h44; in_data = 32'hD44;
    tick();
    flush = 1'b1; in_ctrl = 8'h55; in_data = 32'hE55;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_out_valid", s_out_valid, 0);
    chk("fl_out_ctrl", s_out_ctrl, 0);
    chk("fl_in_ready", s_in_ready, 1);
    chk("fl_data_kept", s_out_data, 32'hC33);
    chk("fl_z_out_valid", z_out_valid, 0);
    chk("fl_data_zeroed", z_out_data, 0);
    chk("fl_stall_kept", s_stall, 3);
    // Flush while empty: upstream handshakes but the entry is killed.
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'h66; in_data = 32'hF66;
    #1;
    chk("fl_empty_in_ready", s_in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_empty_killed", s_out_valid, 0);

    // Stall counter saturation at 15 with CNT_W=4.
    in_valid = 1'b1; in_ctrl = 8'h77; in_data = 32'h777;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_stall", s_stall, 15);
    chk("sat_z_stall", z_stall, 15);
    chk("sat_ctrl_held", s_out_ctrl, 8'h77);
    chk("sat_data_held", s_out_data, 32'h777);
    out_ready = 1'b1;
    tick();
    chk("sat_drain", s_out_valid, 0);
    chk("sat_no_wrap", s_stall, 15);

    // Asynchronous reset while in state TWO.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h88; in_data = 32'h888;
    tick();
    in_ctrl = 8'h99;
    tick();
    in_valid = 1'b0;
    #1;
    chk("ar_pre_in_ready", s_in_ready, 0);
    reset = 1'b0;
    #1;
    chk("ar_out_valid", s_out_valid, 0);
    chk("ar_out_ctrl", s_out_ctrl, 0);
    chk("ar_in_ready", s_in_ready, 1);
    chk("ar_stall", s_stall, 0);
    chk("ar_out_data", s_out_data, 0);
    tick();
    reset = 1'b1;

    // SKID=0: combinational in_ready.
    p_in_valid = 1'b1; p_in_ctrl = 8'h81; p_in_data = 32'h181;
    #1;
    chk("p_empty_in_ready", p_in_ready, 1);
    tick();
    p_in_ctrl = 8'h82; p_in_data = 32'h182;
    #1;
    chk("p_full_in_ready", p_in_ready, 0);
    chk("p_full_ctrl", p_out_ctrl, 8'h81);
    tick();
    chk("p_hold_ctrl", p_out_ctrl, 8'h81);
    chk("p_hold_data", p_out_data, 32'h181);
    chk("p_stall", p_stall, 1);
    p_out_ready = 1'b1;
    #1;
    chk("p_comb_in_ready", p_in_ready, 1);
    tick();
    chk("p_thru_valid", p_out_valid, 1);
    chk("p_thru_ctrl", p_out_ctrl, 8'h82);
    p_in_valid = 1'b0;
    tick();
    chk("p_drain_valid", p_out_valid, 0);
    chk("p_drain_ctrl", p_out_ctrl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
